alpha_fetch_sequencer: RTL

//  Drives the alphanumeric renderer. Generates raster timing, fetches character bytes from video RAM over a
//  req/ack handshake one cell ahead, and presents char_code/inv/row with a one-cycle load strobe per 8-pixel cell.

---
 rtl/alpha_fetch_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alpha_fetch_sequencer.sv
// alpha_fetch_sequencer
//   Raster timing and character fetch for the alphanumeric renderer. Each
//   character byte is fetched from video RAM one cell ahead. The renderer
//   gets char_code/inv/row plus a one-clock load strobe for each 8-pixel cell.
//
// Ports
//   clk, reset_n   system clock, synchronous active-low reset
//   pix_en         one-clock strobe per pixel period; raster counters advance on it
//   base_addr      start of the text page, sampled when a fetch is issued
//   vram_req/addr  fetch request and address toward the VRAM arbiter
//   vram_ack/data  one-clock acknowledge; data is valid in the same clock
//   char_code/inv  character and inverse flag for the cell being loaded
//   row            scanline within the character row (0..11)
//   load           one-clock strobe: renderer takes char_code/inv/row
//   active         visible area (h_cnt < 256 and v_cnt < 192)
//   hsync, vsync   active-high sync pulses
//   underrun       one-clock pulse: a cell was loaded without fresh data
//
// Handshake: vram_req is a valid that stays high, with vram_addr stable,
// until the clock in which vram_ack is high. That clock completes the
// transfer. An ack while vram_req is low is ignored.
module alpha_fetch_sequencer #(
    parameter int ADDR_W   = 13,
    parameter int H_TOTAL  = 320,
    parameter int V_TOTAL  = 262,
    parameter int HS_START = 280,
    parameter int HS_LEN   = 24,
    parameter int VS_START = 225,
    parameter int VS_LEN   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_en,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              vram_req,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic              vram_ack,
    input  logic [7:0]        vram_data,
    output logic [4:0]        char_code,
    output logic              inv,
    output logic [3:0]        row,
    output logic              load,
    output logic              active,
    output logic              hsync,
    output logic              vsync,
    output logic              underrun
);

    localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_PREFETCH = 9'(H_TOTAL - 8);
    localparam logic [8:0] H_ACTIVE   = 9'd256;
    localparam logic [8:0] V_ACTIVE   = 9'd192;
    localparam logic [8:0] HS_S       = 9'(HS_START);
    localparam logic [8:0] HS_E       = 9'(HS_START + HS_LEN);
    localparam logic [8:0] VS_S       = 9'(VS_START);
    localparam logic [8:0] VS_E       = 9'(VS_START + VS_LEN);

    typedef enum logic {FETCH_IDLE, FETCH_WAIT} fetch_state_t;

    fetch_state_t fetch_state;

    logic [8:0] h_cnt, v_cnt;
    logic [3:0] line_in_row;
    logic [4:0] char_row;        // counts past 15 during vertical blanking

    logic [4:0] req_tag;         // target cell of the outstanding fetch
    logic       next_buf_valid;
    logic [4:0] next_buf_code;
    logic       next_buf_inv;
    logic [4:0] next_buf_tag;

    logic [8:0] h_nx, v_nx;
    logic       boundary, cell_active, load_now;
    logic [4:0] col;
    logic [8:0] v_next_line;
    logic [4:0] next_char_row;
    logic       issue_same, issue_next, issue;
    logic [4:0] tgt_col, tgt_row;
    logic       ack_hit, bypass, buf_hit, fresh;

    logic unused_data_bits;
    assign unused_data_bits = vram_data[7] ^ vram_data[5];

    assign vram_req = (fetch_state == FETCH_WAIT);

    always_comb begin
        h_nx = h_cnt;
        v_nx = v_cnt;
        if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_nx = 9'd0;
                v_nx = (v_cnt == V_LAST) ? 9'd0 : v_cnt + 9'd1;
            end else begin
                h_nx = h_cnt + 9'd1;
            end
        end
    end

    assign boundary    = pix_en && (h_cnt[2:0] == 3'd0);
    assign cell_active = (v_cnt < V_ACTIVE) && (h_cnt < H_ACTIVE);
    assign load_now    = boundary && cell_active;
    assign col         = h_cnt[7:3];

    // Character row of the following line, used by the end-of-line prefetch.
    assign v_next_line   = (v_cnt == V_LAST) ? 9'd0 : v_cnt + 9'd1;
    assign next_char_row = (v_cnt == V_LAST)       ? 5'd0 :
                           (line_in_row == 4'd11) ? char_row + 5'd1 : char_row;

    // A fetch completing in this clock frees the slot, so a new fetch can
    // issue in the same clock.
    assign issue_same = load_now && (col != 5'd31);
    assign issue_next = boundary && (h_cnt == H_PREFETCH) && (v_next_line < V_ACTIVE);
    assign ack_hit    = vram_req && vram_ack;
    assign issue      = (issue_same || issue_next) && (!vram_req || vram_ack);
    assign tgt_col    = issue_next ? 5'd0 : col + 5'd1;
    assign tgt_row    = issue_next ? next_char_row : char_row;

    // Data is used only by the cell it was fetched for. An ack arriving on the
    // load boundary itself is forwarded straight to the outputs.
    assign bypass  = ack_hit && (req_tag == col);
    assign buf_hit = next_buf_valid && (next_buf_tag == col);
    assign fresh   = bypass || buf_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_cnt          <= '0;
            v_cnt          <= '0;
            line_in_row    <= '0;
            char_row       <= '0;
            fetch_state    <= FETCH_IDLE;
            vram_addr      <= '0;
            req_tag        <= '0;
            next_buf_valid <= 1'b0;
            next_buf_code  <= '0;
            next_buf_inv   <= 1'b0;
            next_buf_tag   <= '0;
            char_code      <= '0;
            inv            <= 1'b0;
            row            <= '0;
            load           <= 1'b0;
            underrun       <= 1'b0;
            active         <= 1'b0;
            hsync          <= 1'b0;
            vsync          <= 1'b0;
        end else begin
            load     <= 1'b0;
            underrun <= 1'b0;

            if (pix_en) begin
                h_cnt  <= h_nx;
                v_cnt  <= v_nx;
                active <= (h_nx < H_ACTIVE) && (v_nx < V_ACTIVE);
                hsync  <= (h_nx >= HS_S) && (h_nx < HS_E);
                vsync  <= (v_nx >= VS_S) && (v_nx < VS_E);
                if (h_cnt == H_LAST) begin
                    if (v_cnt == V_LAST) begin
                        line_in_row <= '0;
                        char_row    <= '0;
                    end else if (line_in_row == 4'd11) begin
                        line_in_row <= '0;
                        char_row    <= char_row + 5'd1;
                    end else begin
                        line_in_row <= line_in_row + 4'd1;
                    end
                end
            end

            if (issue) begin
                fetch_state <= FETCH_WAIT;
                vram_addr   <= base_addr + ADDR_W'({tgt_row, tgt_col});
                req_tag     <= tgt_col;
            end else if (ack_hit) begin
                fetch_state <= FETCH_IDLE;
            end

            // Every load consumes the buffer. Data with a stale tag is dropped.
            if (ack_hit && !(load_now && bypass)) begin
                next_buf_valid <= 1'b1;
                next_buf_code  <= vram_data[4:0];
                next_buf_inv   <= vram_data[6];
                next_buf_tag   <= req_tag;
            end else if (load_now) begin
                next_buf_valid <= 1'b0;
            end

            if (load_now) begin
                load <= 1'b1;
                row  <= line_in_row;
                if (bypass) begin
                    char_code <= vram_data[4:0];
                    inv       <= vram_data[6];
                end else if (buf_hit) begin
                    char_code <= next_buf_code;
                    inv       <= next_buf_inv;
                end else begin
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule
